// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 clock, deserialises
// 11-bit frames, checks start/parity/stop and folds E0/F0 prefixes into a key event word.
module ps2_kbd_rx #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 43000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [7:0]  scan_code,
   output logic        scan_valid,
   output logic        parity_err,
   output logic        frame_err,
   output logic [10:0] ps2_key
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [15:0] FILT_LAST = 16'(FILTER - 1);
   localparam logic [15:0] TO_MAX    = 16'(TIMEOUT);

   logic [1:0]  clk_sync_q, dat_sync_q;
   logic        filt_q, filt_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic        fall;
   logic        sample;

   state_t      state_q, state_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic [15:0] to_q, to_d;
   logic        ext_q, ext_d;
   logic        rel_q, rel_d;
   logic [7:0]  code_q, code_d;
   logic        valid_q, valid_d;
   logic        perr_q, perr_d;
   logic        ferr_q, ferr_d;
   logic [10:0] key_q, key_d;

   assign sample = dat_sync_q[1];

   // A new clock level is accepted only after FILTER consecutive cycles of disagreement.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      fall   = 1'b0;
      if (clk_sync_q[1] != filt_q) begin
         if (fcnt_q == FILT_LAST) begin
            filt_d = clk_sync_q[1];
            fall   = filt_q;
         end else begin
            fcnt_d = fcnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      ext_d   = ext_q;
      rel_d   = rel_q;
      code_d  = code_q;
      key_d   = key_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      to_d    = (state_q == IDLE) ? 16'd0 : to_q + 16'd1;

      if (fall) begin
         to_d = '0;
         unique case (state_q)
            IDLE: begin
               if (!sample) begin
                  state_d = DATA;
                  bit_d   = '0;
               end
            end
            DATA: begin
               shift_d[bit_q] = sample;
               if (bit_q == 3'd7) begin
                  state_d = PARITY;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
            PARITY: begin
               par_d   = sample;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!sample) begin
                  ferr_d = 1'b1;
                  ext_d  = 1'b0;
                  rel_d  = 1'b0;
               end else if (^{shift_q, par_q}) begin
                  valid_d = 1'b1;
                  code_d  = shift_q;
                  if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     rel_d = 1'b1;
                  end else begin
                     key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                     ext_d = 1'b0;
                     rel_d = 1'b0;
                  end
               end else begin
                  perr_d = 1'b1;
                  ext_d  = 1'b0;
                  rel_d  = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && to_q == TO_MAX) begin
         // Stalled partial frame: drop it and forget any pending prefix.
         state_d = IDLE;
         to_d    = '0;
         ferr_d  = 1'b1;
         ext_d   = 1'b0;
         rel_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
         state_q    <= IDLE;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         to_q       <= '0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         key_q      <= '0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         state_q    <= state_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         to_q       <= to_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         key_q      <= key_d;
      end
   end

   assign scan_code  = code_q;
   assign scan_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign ps2_key    = key_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed plus randomized frames for ps2_kbd_rx, checked against a byte-level model
// of the frame rules and the E0/F0 prefix folding.
module tb_ps2_kbd_rx;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [7:0]  scan_code;
   logic        scan_valid;
   logic        parity_err;
   logic        frame_err;
   logic [10:0] ps2_key;

   ps2_kbd_rx #(.FILTER(8), .TIMEOUT(43000)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .scan_code (scan_code),
      .scan_valid(scan_valid),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .ps2_key   (ps2_key)
   );

   always #5 clk_sys = ~clk_sys;

   int vectors    = 0;
   int miscompares = 0;

   // Observed pulse counts and protocol-level anomalies.
   int          obs_valid = 0, obs_perr = 0, obs_ferr = 0;
   int          overlap = 0, key_bad = 0;
   logic [10:0] key_prev = '0;

   always @(negedge clk_sys) begin
      if (!reset) begin
         if (scan_valid) obs_valid <= obs_valid + 1;
         if (parity_err) obs_perr  <= obs_perr + 1;
         if (frame_err)  obs_ferr  <= obs_ferr + 1;
         if (scan_valid && (parity_err || frame_err)) overlap <= overlap + 1;
         if (ps2_key !== key_prev && !scan_valid) key_bad <= key_bad + 1;
      end
      key_prev <= ps2_key;
   end

   // Reference model state
   int          exp_valid = 0, exp_perr = 0, exp_ferr = 0;
   logic [7:0]  exp_code = '0;
   logic [10:0] exp_key  = '0;
   bit          m_ext = 0, m_rel = 0;

   task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
      int ones;
      ones = $countones(b) + int'(par);
      if (!stp) begin
         exp_ferr++;
         m_ext = 0; m_rel = 0;
      end else if (ones % 2 == 0) begin
         exp_perr++;
         m_ext = 0; m_rel = 0;
      end else begin
         exp_valid++;
         exp_code = b;
         if (b == 8'hE0)      m_ext = 1;
         else if (b == 8'hF0) m_rel = 1;
         else begin
            exp_key = {~exp_key[10], ~m_rel, m_ext, b};
            m_ext = 0; m_rel = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                             input int half, input int nbits, input bit glitch);
      logic [10:0] bits;
      bits = {stp, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         if (glitch) begin
            wait_cycles(half / 2);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(half - half / 2 - 3);
         end else begin
            wait_cycles(half);
         end
         ps2_clk = 1'b0;
         wait_cycles(half);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cycles(half);
   endtask

   task automatic good_frame(input logic [7:0] b, input int half);
      send_frame(b, ~^b, 1'b1, half, 11, 1'b0);
      model_frame(b, ~^b, 1'b1);
   endtask

   task automatic check_all(input string tag);
      wait_cycles(20);
      check({tag, "_valid"}, obs_valid, exp_valid);
      check({tag, "_perr"},  obs_perr,  exp_perr);
      check({tag, "_ferr"},  obs_ferr,  exp_ferr);
      check({tag, "_code"},  scan_code, exp_code);
      check({tag, "_key"},   ps2_key,   exp_key);
   endtask

   initial begin
      logic [7:0] rb;
      logic       rpar, rstp;
      int         mode, half;

      // Reset state
      wait_cycles(5);
      check("rst_code",  scan_code, 0);
      check("rst_valid", scan_valid, 0);
      check("rst_perr",  parity_err, 0);
      check("rst_ferr",  frame_err, 0);
      check("rst_key",   ps2_key, 0);
      reset = 1'b0;
      wait_cycles(5);

      // Single make code at slow timing
      good_frame(8'h1C, 200);
      check_all("make");
      check("make_key_const", ps2_key, 11'h61C);

      // Extended release, back-to-back at minimum half-period
      good_frame(8'hE0, 12);
      good_frame(8'hF0, 12);
      good_frame(8'h75, 12);
      check_all("extrel");

      // Bad parity then a correct frame
      send_frame(8'h1C, 1'b1, 1'b1, 30, 11, 1'b0);
      model_frame(8'h1C, 1'b1, 1'b1);
      check_all("badpar");
      good_frame(8'h1C, 30);
      check_all("afterpar");

      // Timeout recovery: start plus 5 data bits, then silence
      good_frame(8'hE0, 30);
      send_frame(8'h29, 1'b0, 1'b1, 30, 6, 1'b0);
      wait_cycles(42000);
      check("to_early_ferr", obs_ferr, exp_ferr);
      wait_cycles(1100);
      exp_ferr++;
      m_ext = 0; m_rel = 0;
      check_all("timeout");
      good_frame(8'h29, 30);
      check_all("after_to");

      // Glitch rejection
      send_frame(8'h5A, ~^8'h5A, 1'b1, 40, 11, 1'b1);
      model_frame(8'h5A, ~^8'h5A, 1'b1);
      check_all("glitch");

      // Randomized frames, including prefixes and bad parity/stop
      for (int n = 0; n < 14; n++) begin
         mode = int'($urandom_range(0, 9));
         rb   = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0)
                                            : 8'($urandom);
         rpar = ~^rb;
         rstp = 1'b1;
         if (mode == 7 || mode == 8) rpar = ~rpar;
         if (mode == 9) rstp = 1'b0;
         half = int'($urandom_range(14, 40));
         send_frame(rb, rpar, rstp, half, 11, 1'b0);
         model_frame(rb, rpar, rstp);
         check_all("rand");
      end

      // Reset mid-frame
      send_frame(8'h1C, ~^8'h1C, 1'b1, 30, 4, 1'b0);
      reset = 1'b1;
      wait_cycles(3);
      check("midrst_code",  scan_code, 0);
      check("midrst_valid", scan_valid, 0);
      check("midrst_perr",  parity_err, 0);
      check("midrst_ferr",  frame_err, 0);
      check("midrst_key",   ps2_key, 0);
      exp_code = '0; exp_key = '0; m_ext = 0; m_rel = 0;
      reset = 1'b0;
      wait_cycles(5);
      good_frame(8'h16, 30);
      check_all("midrst_after");
      check("midrst_key_const", ps2_key, 11'h616);

      check("pulse_overlap", overlap, 0);
      check("key_without_valid", key_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
